// File: rtl/max_unpooling_if.sv
// Handshake bundle for the max_unpooling block: the pooled-value input stream
// (value + argmax tag) and the reconstructed-pixel output stream.
interface max_unpooling_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_idx;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/max_unpooling.sv
// Streaming 2x2 max-unpooling: four pooled beats (value + argmax position) are
// scattered into a 4x4 frame buffer, then the 16 pixels are emitted row-major.
// Optional build macro UNPOOL_NEAREST_EN: nearest-neighbour fill of the whole
// window instead of argmax scatter (handshake and timing unchanged).
module max_unpooling #(
    parameter int DATA_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    max_unpooling_if.slave   bus,
    output logic             busy
);
    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        win_q;
    logic [3:0]        pix_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] frame_q [16];
    logic              in_fire;
    logic              out_fire;

    // Buffer address of sub-cell `sub` (row offset in bit 1, column in bit 0)
    // inside quadrant `win`: row = {win[1], sub[1]}, col = {win[0], sub[0]}.
    function automatic logic [3:0] cell_index(input logic [1:0] win,
                                              input logic [1:0] sub);
        return {win[1], sub[1], win[0], sub[0]};
    endfunction

    // Value written into one sub-cell of the current window.
    function automatic logic [DATA_W-1:0] cell_value(input logic [1:0]        sub,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [1:0]        idx);
`ifdef UNPOOL_NEAREST_EN
        logic [1:0] unused_sel;
        unused_sel = sub ^ idx;
        return (unused_sel == unused_sel) ? data : '0;
`else
        return (sub == idx) ? data : '0;
`endif
    endfunction

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // Next-state: LOAD leaves on the 4th accept, EMIT leaves on the 16th transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: if (in_fire && win_q == 2'd3) state_d = EMIT;
            EMIT: if (out_fire && pix_q == 4'd15) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // State, registered handshake flags and the window/pixel counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            win_q       <= 2'd0;
            pix_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == LOAD);
            out_valid_q <= (state_d == EMIT);
            if (in_fire) win_q <= win_q + 2'd1;
            if (out_fire) pix_q <= pix_q + 4'd1;
        end
    end

    // Each accepted beat rewrites all four cells of its window, so no frame clear is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) frame_q[i] <= '0;
        end else if (in_fire) begin
            for (int s = 0; s < 4; s++)
                frame_q[cell_index(win_q, 2'(s))] <= cell_value(2'(s), bus.in_data, bus.in_idx);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = frame_q[pix_q];
    assign bus.out_last  = (pix_q == 4'd15);
    assign busy          = (state_q == EMIT) | (win_q != 2'd0);
endmodule

// File: tb/tb_max_unpooling.sv
// Self-checking bench for max_unpooling: fixed argmax frame, randomized frames
// with output backpressure, input gaps/lockout, and mid-frame reset.
module tb_max_unpooling;
    localparam int DATA_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    logic [DATA_W-1:0] exp_frame [16];
    logic [DATA_W-1:0] beat_d [4];
    logic [1:0]        beat_i [4];

    max_unpooling_if #(.DATA_W(DATA_W)) ifc ();

    max_unpooling #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: window k sits at quadrant (k/2, k%2); argmax position p sits at
    // offset (p/2, p%2) inside it.
    function automatic void build_expected();
        for (int k = 0; k < 4; k++)
            for (int p = 0; p < 4; p++) begin
                int r, c;
                r = (k / 2) * 2 + p / 2;
                c = (k % 2) * 2 + p % 2;
`ifdef UNPOOL_NEAREST_EN
                exp_frame[r * 4 + c] = beat_d[k];
`else
                exp_frame[r * 4 + c] = (p == int'(beat_i[k])) ? beat_d[k] : '0;
`endif
            end
    endfunction

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [1:0] ix);
        int cyc = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_idx   = ix;
        while (ifc.in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 50) begin
            errors++;
            $display("FAIL beat_accept_timeout: in_ready=%b required 1", ifc.in_ready);
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    // Sends beat_d/beat_i; checks busy and the first-pixel latency after each accept.
    task automatic send_frame(input int gap);
        for (int k = 0; k < 4; k++) begin
            send_beat(beat_d[k], beat_i[k]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_beat%0d: got %b required 1", k, busy);
            end
            checks++;
            if (ifc.out_valid !== (k == 3)) begin
                errors++;
                $display("FAIL out_valid_after_beat%0d: got %b required %b", k, ifc.out_valid, (k == 3));
            end
            if (k < 3) repeat (gap) @(negedge clk);
        end
    endtask

    // Collects n pixels; rnd toggles out_ready. Checks data, last flag, stall
    // stability and input lockout. After a full frame checks return to LOAD.
    task automatic collect(input int n, input bit rnd);
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [DATA_W-1:0] held_d = '0;
        logic held_l = 1'b0;
        while (got < n && cyc < 500) begin
            if (ifc.out_valid === 1'b1 && ifc.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL lockout: in_ready=%b during EMIT pix=%0d", ifc.in_ready, got);
            end
            checks++;
            if (stalled) begin
                checks++;
                if (ifc.out_valid !== 1'b1 || ifc.out_data !== held_d || ifc.out_last !== held_l) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%0d last=%b required 1/%0d/%b",
                             ifc.out_valid, ifc.out_data, ifc.out_last, held_d, held_l);
                end
            end
            ifc.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ifc.out_valid === 1'b1 && ifc.out_ready) begin
                checks++;
                if (ifc.out_data !== exp_frame[got]) begin
                    errors++;
                    $display("FAIL pixel%0d: got %0d required %0d", got, ifc.out_data, exp_frame[got]);
                end
                checks++;
                if (ifc.out_last !== (got == 15)) begin
                    errors++;
                    $display("FAIL last%0d: got %b required %b", got, ifc.out_last, (got == 15));
                end
                got++;
                stalled = 1'b0;
            end else if (ifc.out_valid === 1'b1) begin
                stalled = 1'b1;
                held_d  = ifc.out_data;
                held_l  = ifc.out_last;
            end
            @(negedge clk);
            cyc++;
        end
        ifc.out_ready = 1'b0;
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL collect_timeout: got %0d pixels required %0d", got, n);
        end
        if (n == 16) begin
            checks++;
            if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL return_to_load: in_ready=%b out_valid=%b required 1/0",
                         ifc.in_ready, ifc.out_valid);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.out_data !== '0 ||
            ifc.out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%b valid=%b data=%0d last=%b busy=%b required all 0",
                     tag, ifc.in_ready, ifc.out_valid, ifc.out_data, ifc.out_last, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_hold");
        rst_n = 1'b1;
        #1;
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", ifc.in_ready);
        end
        @(negedge clk);
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_release: ready=%b valid=%b busy=%b required 1/0/0",
                     ifc.in_ready, ifc.out_valid, busy);
        end
    endtask

    task automatic test_argmax();
        logic [DATA_W-1:0] ref_tab [16];
`ifdef UNPOOL_NEAREST_EN
        ref_tab = '{6, 6, 8, 8, 6, 6, 8, 8, 4, 4, 5, 5, 4, 4, 5, 5};
`else
        ref_tab = '{0, 0, 0, 0, 6, 0, 8, 0, 0, 4, 0, 0, 0, 0, 5, 0};
`endif
        beat_d = '{6, 8, 4, 5};
        beat_i = '{2, 2, 1, 2};
        exp_frame = ref_tab;
        send_frame(0);
        collect(16, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int f = 0; f < 6; f++) begin
            if (f == 0) begin
                beat_d = '{6, 8, 4, 5};
                beat_i = '{2, 2, 1, 2};
            end else
                for (int k = 0; k < 4; k++) begin
                    beat_d[k] = DATA_W'($urandom);
                    beat_i[k] = 2'($urandom);
                end
            build_expected();
            send_frame(0);
            collect(16, 1'b1);
        end
    endtask

    task automatic test_gaps_lockout();
        for (int k = 0; k < 4; k++) begin
            beat_d[k] = DATA_W'($urandom_range(1, 15));
            beat_i[k] = 2'($urandom);
        end
        build_expected();
        send_frame(3);
        ifc.in_valid = 1'b1;
        ifc.in_data  = 4'd9;
        ifc.in_idx   = 2'd0;
        collect(16, 1'b0);
        ifc.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_frame: busy=%b in_ready=%b required 0/1", busy, ifc.in_ready);
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 4; k++) begin
            beat_d[k] = DATA_W'($urandom_range(1, 15));
            beat_i[k] = 2'($urandom);
        end
        build_expected();
        send_frame(0);
        collect(7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_midframe");
        repeat (2) @(negedge clk);
        check_reset_values("reset_midframe_hold");
        rst_n = 1'b1;
        @(negedge clk);
        beat_d = '{15, 15, 15, 15};
        beat_i = '{3, 3, 3, 3};
        build_expected();
        send_frame(0);
        collect(16, 1'b0);
    endtask

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_idx    = 2'd0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_argmax();
        test_backpressure();
        test_gaps_lockout();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
